uart_mmio_fifo_bridge: RTL and testbench

//  Memory-mapped bridge between the single-cycle core's data bus and the UART RX/TX engines.

---
 rtl/uart_mmio_fifo_bridge.sv | 163 ++++++++++++++++
 tb/tb_uart_mmio_fifo_bridge.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo_bridge.sv
// MMIO bridge between the core data bus and the UART engines.
// It holds an RX FIFO and a TX FIFO, and a TX FSM feeds the transmitter through a start/busy handshake.
module uart_mmio_fifo_bridge #(
   parameter int DATA_W   = 8,
   parameter int RX_DEPTH = 8,
   parameter int TX_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        bus_addr,
   input  logic              bus_we,
   input  logic              bus_re,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              tx_busy,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   output logic              irq
);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int TAW = $clog2(TX_DEPTH);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_t;

   typedef struct packed {
      logic tx_active;
      logic tx_ovf;
      logic rx_ovf;
      logic tx_full;
      logic tx_empty;
      logic rx_full;
      logic rx_nempty;
   } status_t;

   logic [DATA_W-1:0] rx_mem [RX_DEPTH];
   logic [DATA_W-1:0] tx_mem [TX_DEPTH];
   logic [RAW-1:0]    rx_wp, rx_rp;
   logic [TAW-1:0]    tx_wp, tx_rp;
   logic [RAW:0]      rx_cnt;
   logic [TAW:0]      tx_cnt;
   logic              rx_ovf, tx_ovf, rx_irq_en, tx_irq_en;
   tx_state_t         state;
   status_t           status;

   logic wr_data, wr_stat, wr_ctrl, rd_data;
   logic rx_flush, tx_flush, rx_empty, rx_full, tx_empty, tx_full;
   logic rx_pop, rx_push, rx_drop, tx_pop, tx_push, tx_drop, tx_active;
   logic unused_wdata;

   assign wr_data  = bus_we && bus_addr == 2'd0;
   assign wr_stat  = bus_we && bus_addr == 2'd1;
   assign wr_ctrl  = bus_we && bus_addr == 2'd2;
   assign rd_data  = bus_re && bus_addr == 2'd0;
   assign rx_flush = wr_ctrl && bus_wdata[2];
   assign tx_flush = wr_ctrl && bus_wdata[3];

   assign rx_empty  = rx_cnt == '0;
   assign rx_full   = rx_cnt == (RAW+1)'(RX_DEPTH);
   assign tx_empty  = tx_cnt == '0;
   assign tx_full   = tx_cnt == (TAW+1)'(TX_DEPTH);
   assign tx_active = state != IDLE;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign rx_pop  = rd_data && !rx_empty;
   assign rx_push = rx_valid && (!rx_full || rx_pop);
   assign rx_drop = rx_valid && rx_full && !rx_pop;
   assign tx_pop  = state == LOAD;
   assign tx_push = wr_data && (!tx_full || tx_pop);
   assign tx_drop = wr_data && tx_full && !tx_pop;

   assign unused_wdata = ^bus_wdata;

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp] <= rx_data;
      if (tx_push) tx_mem[tx_wp] <= bus_wdata[DATA_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      end else if (rx_flush) begin
         rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
         rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      end else if (tx_flush) begin
         tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
         tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_ovf    <= 1'b0;
         tx_ovf    <= 1'b0;
         rx_irq_en <= 1'b0;
         tx_irq_en <= 1'b0;
      end else begin
         rx_ovf <= rx_drop || (rx_ovf && !(wr_stat && bus_wdata[4]));
         tx_ovf <= tx_drop || (tx_ovf && !(wr_stat && bus_wdata[5]));
         if (wr_ctrl) begin
            rx_irq_en <= bus_wdata[0];
            tx_irq_en <= bus_wdata[1];
         end
      end
   end

   // tx_data is captured on entry to LOAD, so it is valid for the whole tx_start cycle.
   // The head is popped when LOAD exits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            IDLE:
               if (!tx_empty && !tx_busy && !tx_flush) begin
                  state    <= LOAD;
                  tx_start <= 1'b1;
                  tx_data  <= tx_mem[tx_rp];
               end
            LOAD:      state <= WAIT_BUSY;
            WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
            WAIT_DONE: if (!tx_busy) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

   always_comb begin
      status = '{tx_active: tx_active, tx_ovf: tx_ovf, rx_ovf: rx_ovf, tx_full: tx_full,
                 tx_empty: tx_empty, rx_full: rx_full, rx_nempty: !rx_empty};
   end

   always_comb begin
      bus_rdata = '0;
      case (bus_addr)
         2'd0: if (!rx_empty) bus_rdata[DATA_W-1:0] = rx_mem[rx_rp];
         2'd1: bus_rdata[6:0] = status;
         2'd2: bus_rdata[1:0] = {tx_irq_en, rx_irq_en};
         default: begin
            bus_rdata[RAW:0]     = rx_cnt;
            bus_rdata[8 +: TAW+1] = tx_cnt;
         end
      endcase
   end

   assign irq = (rx_irq_en && !rx_empty) || (tx_irq_en && tx_empty && !tx_active);
endmodule

// File: tb/tb_uart_mmio_fifo_bridge.sv
// Directed bench for uart_mmio_fifo_bridge.
// A small transmitter model drives tx_busy after each tx_start and logs every character it is handed.
module tb_uart_mmio_fifo_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  bus_addr;
   logic        bus_we, bus_re;
   logic [31:0] bus_wdata, bus_rdata;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        tx_busy = 1'b0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        irq;

   int vectors = 0;
   int errs    = 0;
   int lag     = 0;
   int pre     = 0;
   int bc      = 0;
   logic [7:0]  txlog [$];
   logic [31:0] d;

   uart_mmio_fifo_bridge #(.DATA_W(8), .RX_DEPTH(8), .TX_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .irq(irq)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy rises lag cycles after tx_start and stays high for 10 cycles.
   always @(negedge clk) begin
      if (rst) begin
         pre = 0; bc = 0;
      end else if (tx_start) begin
         txlog.push_back(tx_data);
         if (lag == 0) bc = 10; else pre = lag;
      end else if (pre > 0) begin
         pre = pre - 1;
         if (pre == 0) bc = 10;
      end else if (bc > 0) begin
         bc = bc - 1;
      end
      tx_busy = bc != 0;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] v);
      bus_addr = a; bus_wdata = v; bus_we = 1'b1;
      @(negedge clk);
      bus_we = 1'b0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] v);
      bus_addr = a; bus_re = 1'b1;
      #1 v = bus_rdata;
      @(negedge clk);
      bus_re = 1'b0;
   endtask

   task automatic peek(input logic [1:0] a, output logic [31:0] v);
      bus_addr = a;
      #1 v = bus_rdata;
   endtask

   task automatic rx_push(input logic [7:0] v);
      rx_data = v; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus_addr = '0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = '0;
      rx_valid = 1'b0; rx_data = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state
      peek(2'd1, d); chk("rst_status", d, 32'h04);
      peek(2'd3, d); chk("rst_count", d, 32'h0);
      peek(2'd2, d); chk("rst_ctrl", d, 32'h0);
      chk("rst_irq", {31'b0, irq}, 32'h0);
      chk("rst_tx_start", {31'b0, tx_start}, 32'h0);
      chk("rst_tx_data", {24'b0, tx_data}, 32'h0);

      // async reset during WAIT_DONE
      wr(2'd0, 32'h5A);
      repeat (4) @(negedge clk);
      peek(2'd1, d); chk("wait_done_status", d, 32'h44);
      #3 rst = 1'b1;
      #1;
      chk("midrst_tx_start", {31'b0, tx_start}, 32'h0);
      chk("midrst_tx_data", {24'b0, tx_data}, 32'h0);
      chk("midrst_status", bus_rdata, 32'h04);
      @(negedge clk);
      rst = 1'b0;
      txlog.delete();

      // three TX bytes back to back
      wr(2'd0, 32'h41); wr(2'd0, 32'h42); wr(2'd0, 32'h43);
      repeat (60) @(negedge clk);
      chk("tx3_count", txlog.size(), 3);
      chk("tx3_b0", {24'b0, txlog[0]}, 32'h41);
      chk("tx3_b1", {24'b0, txlog[1]}, 32'h42);
      chk("tx3_b2", {24'b0, txlog[2]}, 32'h43);
      peek(2'd1, d); chk("tx3_status", d, 32'h04);

      // RX overflow
      for (int i = 0; i < 9; i++) rx_push(8'h10 + 8'(i));
      peek(2'd3, d); chk("rxovf_count", d, 32'h08);
      peek(2'd1, d); chk("rxovf_status", d, 32'h17);
      for (int i = 0; i < 8; i++) begin
         rd(2'd0, d); chk($sformatf("rxovf_rd%0d", i), d, 32'h10 + i);
      end
      rd(2'd0, d); chk("rx_empty_rd", d, 32'h0);
      peek(2'd1, d); chk("rx_empty_status", d, 32'h14);
      wr(2'd1, 32'h10);
      peek(2'd1, d); chk("rxovf_w1c", d, 32'h04);

      // simultaneous pop and push when RX is full
      for (int i = 0; i < 8; i++) rx_push(8'h20 + 8'(i));
      bus_addr = 2'd0; bus_re = 1'b1; rx_data = 8'h99; rx_valid = 1'b1;
      #1 d = bus_rdata;
      @(negedge clk);
      bus_re = 1'b0; rx_valid = 1'b0;
      chk("popush_rd", d, 32'h20);
      peek(2'd3, d); chk("popush_count", d, 32'h08);
      peek(2'd1, d); chk("popush_status", d, 32'h07);
      for (int i = 1; i < 8; i++) begin
         rd(2'd0, d); chk($sformatf("popush_rd%0d", i), d, 32'h20 + i);
      end
      rd(2'd0, d); chk("popush_last", d, 32'h99);
      peek(2'd3, d); chk("popush_drained", d, 32'h0);

      // interrupts
      wr(2'd2, 32'h1);
      chk("irq_rx_empty", {31'b0, irq}, 32'h0);
      rx_push(8'h33);
      chk("irq_rx_set", {31'b0, irq}, 32'h1);
      rd(2'd0, d); chk("irq_rx_data", d, 32'h33);
      chk("irq_rx_clr", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h2);
      chk("irq_tx_idle", {31'b0, irq}, 32'h1);
      peek(2'd2, d); chk("ctrl_rb", d, 32'h2);
      wr(2'd2, 32'h0);
      chk("irq_off", {31'b0, irq}, 32'h0);

      // tx_flush while WAIT_BUSY: in-flight byte completes, queue discarded
      txlog.delete();
      lag = 5;
      wr(2'd0, 32'h51); wr(2'd0, 32'h52); wr(2'd0, 32'h53); wr(2'd0, 32'h54);
      chk("flush_started", txlog.size(), 1);
      wr(2'd2, 32'h8);
      peek(2'd3, d); chk("flush_count", d, 32'h0);
      peek(2'd1, d); chk("flush_status_busy", d, 32'h44);
      repeat (40) @(negedge clk);
      chk("flush_nstarts", txlog.size(), 1);
      chk("flush_byte", {24'b0, txlog[0]}, 32'h51);
      peek(2'd1, d); chk("flush_status_idle", d, 32'h04);
      chk("flush_tx_data", {24'b0, tx_data}, 32'h51);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
